// File: rtl/ub_pipe_bka_if.sv
// Handshake and data bundle for the pipelined Brent-Kung adder/accumulator.
// W is derived from the operand widths; the producer side uses the master modport.
interface ub_pipe_bka_if #(
  parameter int XW = 8,
  parameter int YW = 12
);
  localparam int W = (XW > YW) ? XW : YW;

  logic          IV;
  logic          IR;
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
  logic          CIN;
  logic          MODE;
  logic          CLR;
  logic          OV;
  logic          OR;
  logic [W:0]    S;
  logic [W-1:0]  ACC;
  logic          ACOV;

  modport master (
    output IV, X, Y, CIN, MODE, CLR, OR,
    input  IR, OV, S, ACC, ACOV
  );

  modport slave (
    input  IV, X, Y, CIN, MODE, CLR, OR,
    output IR, OV, S, ACC, ACOV
  );
endinterface

// File: rtl/ub_pipe_bka.sv
// Three-stage Brent-Kung adder with an accumulate mode: GP formation, up-sweep,
// then down-sweep plus sum into the output register. One global stall enable.
module ub_pipe_bka #(
  parameter int XW = 8,
  parameter int YW = 12
) (
  input  logic         CLK,
  input  logic         RST,
  ub_pipe_bka_if.slave bus
);
  localparam int W = (XW > YW) ? XW : YW;
  localparam int L = $clog2(W);

  logic en;
  logic abusy;
  logic xfer;

  logic         v1_q, v1_d, m1_q, m1_d, c1_q, c1_d;
  logic [W-1:0] g1_q, g1_d, p1_q, p1_d;

  logic         v2_q, v2_d, m2_q, m2_d, c2_q, c2_d;
  logic [W-1:0] g2_q, g2_d, p2_q, p2_d;
  logic [W-1:0] p0_q, p0_d;

  logic         ov_q, ov_d, m3_q, m3_d;
  logic [W:0]   s_q, s_d;
  logic [W-1:0] acc_q, acc_d;
  logic         acov_q, acov_d;

  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] dg;
  logic [W:0]   sum;

  assign en     = !ov_q | bus.OR;
  assign abusy  = (v1_q & m1_q) | (v2_q & m2_q) | (ov_q & m3_q);
  assign bus.IR = en & !RST & !(bus.IV & bus.MODE & abusy);
  assign xfer   = bus.IV & bus.IR;

  assign bus.OV   = ov_q;
  assign bus.S    = s_q;
  assign bus.ACC  = acc_q;
  assign bus.ACOV = acov_q;

  // Stage 1: CIN is folded into bit 0 generate so the tree yields carries directly.
  always_comb begin
    a_ext = '0;
    a_ext[XW-1:0] = bus.X;
    b_ext = '0;
    b_ext[YW-1:0] = bus.Y;
    if (bus.MODE) b_ext = acc_q;

    v1_d = v1_q;
    m1_d = m1_q;
    c1_d = c1_q;
    g1_d = g1_q;
    p1_d = p1_q;
    if (en) begin
      v1_d    = xfer;
      m1_d    = bus.MODE;
      c1_d    = bus.CIN;
      p1_d    = a_ext ^ b_ext;
      g1_d    = a_ext & b_ext;
      g1_d[0] = g1_d[0] | (p1_d[0] & bus.CIN);
    end
  end

  // Stage 2: up-sweep; node i at level l absorbs the span ending 2^(l-1) below it.
  always_comb begin
    v2_d = v2_q;
    m2_d = m2_q;
    c2_d = c2_q;
    p0_d = p0_q;
    g2_d = g2_q;
    p2_d = p2_q;
    if (en) begin
      v2_d = v1_q;
      m2_d = m1_q;
      c2_d = c1_q;
      p0_d = p1_q;
      g2_d = g1_q;
      p2_d = p1_q;
      for (int l = 1; l <= L; l++) begin
        for (int i = (1 << l) - 1; i < W; i += (1 << l)) begin
          g2_d[i] = g2_d[i] | (g2_d[i - (1 << (l - 1))] & p2_d[i]);
          p2_d[i] = p2_d[i] & p2_d[i - (1 << (l - 1))];
        end
      end
    end
  end

  // Stage 3: down-sweep fills the remaining prefixes; only group generates are needed.
  always_comb begin
    dg = g2_q;
    for (int l = L - 1; l >= 1; l--) begin
      for (int i = (1 << l) + (1 << (l - 1)) - 1; i < W; i += (1 << l)) begin
        dg[i] = dg[i] | (dg[i - (1 << (l - 1))] & p2_q[i]);
      end
    end
    sum    = '0;
    sum[0] = p0_q[0] ^ c2_q;
    for (int i = 1; i < W; i++) begin
      sum[i] = p0_q[i] ^ dg[i-1];
    end
    sum[W] = dg[W-1];
  end

  always_comb begin
    ov_d   = ov_q;
    m3_d   = m3_q;
    s_d    = s_q;
    acc_d  = acc_q;
    acov_d = acov_q;
    if (en) begin
      ov_d = v2_q;
      m3_d = v2_q & m2_q;
      if (v2_q) s_d = sum;
      if (v2_q & m2_q) begin
        acc_d  = sum[W-1:0];
        acov_d = acov_q | sum[W];
      end
    end
    if (bus.CLR) begin
      acc_d  = '0;
      acov_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_q   <= 1'b0;
      m1_q   <= 1'b0;
      c1_q   <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      v2_q   <= 1'b0;
      m2_q   <= 1'b0;
      c2_q   <= 1'b0;
      g2_q   <= '0;
      p2_q   <= '0;
      p0_q   <= '0;
      ov_q   <= 1'b0;
      m3_q   <= 1'b0;
      s_q    <= '0;
      acc_q  <= '0;
      acov_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      m1_q   <= m1_d;
      c1_q   <= c1_d;
      g1_q   <= g1_d;
      p1_q   <= p1_d;
      v2_q   <= v2_d;
      m2_q   <= m2_d;
      c2_q   <= c2_d;
      g2_q   <= g2_d;
      p2_q   <= p2_d;
      p0_q   <= p0_d;
      ov_q   <= ov_d;
      m3_q   <= m3_d;
      s_q    <= s_d;
      acc_q  <= acc_d;
      acov_q <= acov_d;
    end
  end
endmodule

// File: tb/tb_ub_pipe_bka.sv
// Directed bench for ub_pipe_bka (XW=8, YW=12): add, streaming, stall,
// accumulate, wrap, clear priority and mid-flight reset.
module tb_ub_pipe_bka;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  ub_pipe_bka_if #(.XW(8), .YW(12)) bus ();

  ub_pipe_bka #(.XW(8), .YW(12)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  sx [8] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h55, 8'hAA, 8'h12, 8'hFE};
  logic [11:0] sy [8] = '{12'h000, 12'h001, 12'h001, 12'hF80, 12'hAAA, 12'h555, 12'h345, 12'hF01};
  logic        sc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [12:0] se [8] = '{13'h0000, 13'h0002, 13'h0100, 13'h1001, 13'h0AFF, 13'h0600, 13'h0358, 13'h1000};

  logic [7:0]  bx [4] = '{8'h10, 8'h01, 8'h7F, 8'h03};
  logic [11:0] by [4] = '{12'h020, 12'hFFF, 12'h001, 12'h004};
  logic        bc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one transaction, waits (bounded) for IR, and returns once it sits in the output register.
  task automatic send(input logic mode, input logic [7:0] x, input logic [11:0] y, input logic cin);
    int n;
    n = 0;
    bus.IV = 1'b1; bus.MODE = mode; bus.X = x; bus.Y = y; bus.CIN = cin;
    #1;
    while (!bus.IR && n < 10) begin
      step();
      n++;
    end
    if (n == 10) chk("send_ir_timeout", bus.IR, 1);
    step();
    bus.IV = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.IV = 0; bus.X = 0; bus.Y = 0; bus.CIN = 0; bus.MODE = 0; bus.CLR = 0; bus.OR = 0;
    step();
    step();
    chk("rst_ir", bus.IR, 0);
    chk("rst_ov", bus.OV, 0);
    chk("rst_s", bus.S, 0);
    chk("rst_acc", bus.ACC, 0);
    chk("rst_acov", bus.ACOV, 0);
    rst = 1'b0;
    #1;
    chk("rel_ir", bus.IR, 1);

    // max add, latency
    bus.OR = 1; bus.IV = 1; bus.X = 8'hFF; bus.Y = 12'hFFF; bus.CIN = 1; bus.MODE = 0;
    step();
    bus.IV = 0;
    step();
    chk("max_ov_early", bus.OV, 0);
    step();
    chk("max_ov", bus.OV, 1);
    chk("max_s", bus.S, 13'h10FF);
    chk("max_acc", bus.ACC, 0);
    step();
    chk("max_ov_drop", bus.OV, 0);

    // streaming
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        bus.IV = 1; bus.X = sx[c]; bus.Y = sy[c]; bus.CIN = sc[c]; bus.MODE = 0;
        #1;
        chk($sformatf("str_ir%0d", c), bus.IR, 1);
      end else begin
        bus.IV = 0;
      end
      step();
      if (c >= 2) begin
        chk($sformatf("str_ov%0d", c - 2), bus.OV, 1);
        chk($sformatf("str_s%0d", c - 2), bus.S, se[c-2]);
      end
    end
    step();
    chk("str_ov_drop", bus.OV, 0);

    // backpressure
    bus.OR = 0;
    for (int k = 0; k < 3; k++) begin
      bus.IV = 1; bus.X = bx[k]; bus.Y = by[k]; bus.CIN = bc[k];
      #1;
      chk($sformatf("bp_ir_fill%0d", k), bus.IR, 1);
      step();
    end
    chk("bp_ov_up", bus.OV, 1);
    chk("bp_s0", bus.S, 13'h0030);
    bus.IV = 1; bus.X = bx[3]; bus.Y = by[3]; bus.CIN = bc[3];
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_ir_stall%0d", k), bus.IR, 0);
      chk($sformatf("bp_ov_stall%0d", k), bus.OV, 1);
      chk($sformatf("bp_s_stall%0d", k), bus.S, 13'h0030);
      step();
    end
    bus.OR = 1;
    #1;
    chk("bp_ir_go", bus.IR, 1);
    step();
    bus.IV = 0;
    chk("bp_ov1", bus.OV, 1);
    chk("bp_s1", bus.S, 13'h1000);
    step();
    chk("bp_s2", bus.S, 13'h0081);
    step();
    chk("bp_ov3", bus.OV, 1);
    chk("bp_s3", bus.S, 13'h0007);
    step();
    chk("bp_ov_drop", bus.OV, 0);
    chk("bp_acc", bus.ACC, 0);

    // accumulate hazard
    bus.CLR = 1;
    step();
    bus.CLR = 0;
    chk("acc_clr", bus.ACC, 0);
    bus.IV = 1; bus.MODE = 1; bus.X = 8'h05; bus.Y = 12'h777; bus.CIN = 0;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk($sformatf("acc_ir_open%0d", t), bus.IR, 1);
      step();
      chk($sformatf("acc_ir_busy1_%0d", t), bus.IR, 0);
      step();
      chk($sformatf("acc_ir_busy2_%0d", t), bus.IR, 0);
      step();
      chk($sformatf("acc_ir_busy3_%0d", t), bus.IR, 0);
      chk($sformatf("acc_ov%0d", t), bus.OV, 1);
      chk($sformatf("acc_val%0d", t), bus.ACC, 5 * (t + 1));
      chk($sformatf("acc_s%0d", t), bus.S, 5 * (t + 1));
      step();
    end
    bus.IV = 0;
    chk("acc_final", bus.ACC, 12'h00F);
    chk("acc_acov", bus.ACOV, 0);

    // wrap
    bus.CLR = 1;
    step();
    bus.CLR = 0;
    send(1, 8'hFF, 12'h000, 0);
    chk("wrap_pre1", bus.ACC, 12'h0FF);
    for (int k = 0; k < 15; k++) send(1, 8'hFF, 12'h000, 1);
    chk("wrap_pre", bus.ACC, 12'hFFF);
    chk("wrap_pre_acov", bus.ACOV, 0);
    send(1, 8'h01, 12'h000, 0);
    chk("wrap_s", bus.S, 13'h1000);
    chk("wrap_acc", bus.ACC, 0);
    chk("wrap_acov", bus.ACOV, 1);
    send(0, 8'h02, 12'h003, 0);
    chk("m0_s", bus.S, 13'h0005);
    chk("m0_acc", bus.ACC, 0);
    chk("m0_acov_sticky", bus.ACOV, 1);
    bus.CLR = 1;
    step();
    bus.CLR = 0;
    chk("clr_acc", bus.ACC, 0);
    chk("clr_acov", bus.ACOV, 0);

    // clear wins over a same-edge write-back
    bus.IV = 1; bus.MODE = 1; bus.X = 8'h03; bus.CIN = 0;
    #1;
    chk("pri_ir", bus.IR, 1);
    step();
    bus.IV = 0;
    step();
    bus.CLR = 1;
    step();
    bus.CLR = 0;
    chk("pri_ov", bus.OV, 1);
    chk("pri_s", bus.S, 13'h0003);
    chk("pri_acc", bus.ACC, 0);

    // reset mid-flight
    send(1, 8'h07, 12'h000, 0);
    chk("rmf_pre_acc", bus.ACC, 12'h007);
    step();
    bus.IV = 1; bus.MODE = 0; bus.X = 8'h11; bus.Y = 12'h022; bus.CIN = 0;
    #1;
    chk("rmf_ir1", bus.IR, 1);
    step();
    bus.MODE = 1; bus.X = 8'h09;
    #1;
    chk("rmf_ir2", bus.IR, 1);
    step();
    bus.IV = 0;
    rst = 1;
    #1;
    chk("rmf_ir_rst", bus.IR, 0);
    step();
    rst = 0;
    #1;
    chk("rmf_ir_rel", bus.IR, 1);
    chk("rmf_acc", bus.ACC, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rmf_ov%0d", k), bus.OV, 0);
    end
    chk("rmf_acc_end", bus.ACC, 0);
    chk("rmf_acov_end", bus.ACOV, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
